// File: rtl/sdram_arb_pkg.sv
// Shared types and widths for the two-port SDRAM burst arbiter.
package sdram_arb_pkg;

  localparam int ADDR_W        = 15;
  localparam int DATA_W        = 16;
  localparam int CNT_W         = 10;
  localparam int BURST_LEN_DEF = 512;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_BURST = 2'd2
  } state_t;

endpackage

// File: rtl/sdram_arb_prio.sv
// Fixed priority to port 0 with a starvation counter that hands the next
// contested arbitration to port 1 after STARVE_MAX consecutive port-0 wins.
module sdram_arb_prio
  import sdram_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic CLK_OUT,
  input  logic rst_n,
  input  logic i_arb_en,
  input  logic i_req0,
  input  logic i_req1,
  output logic o_win
);

  localparam int SW = $clog2(STARVE_MAX + 2);

  logic [SW-1:0] r_starve;
  logic          w_starved;

  assign w_starved = (r_starve == SW'(STARVE_MAX));
  assign o_win     = i_req1 && (!i_req0 || w_starved);

  always_ff @(posedge CLK_OUT or negedge rst_n) begin
    if (!rst_n) begin
      r_starve <= '0;
    end else if (i_arb_en) begin
      if (!o_win && i_req1) begin
        if (!w_starved) r_starve <= r_starve + SW'(1);
      end else begin
        r_starve <= '0;
      end
    end
  end

endmodule

// File: rtl/sdram_arbiter.sv
// Two-port full-page burst arbiter in front of a single SDRAM controller.
// Owner, direction and address are latched at grant and held for the burst.
//   state    | meaning
//   ST_IDLE  | waiting for c_ready and a request; arbitration happens here
//   ST_ISSUE | command registered, c_rw_en pulse being launched
//   ST_BURST | words routed to/from the owner until BURST_LEN reached
module sdram_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int BURST_LEN  = BURST_LEN_DEF,
  parameter int STARVE_MAX = 4
) (
  input  logic              CLK_OUT,
  input  logic              rst_n,
  input  logic              p0_req,
  input  logic              p1_req,
  input  logic              p0_rw,
  input  logic              p1_rw,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p0_grant,
  output logic              p1_grant,
  output logic              p0_wreq,
  output logic              p1_wreq,
  output logic [DATA_W-1:0] p0_rdata,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              p0_rvalid,
  output logic              p1_rvalid,
  output logic              p0_done,
  output logic              p1_done,
  output logic              c_rw,
  output logic              c_rw_en,
  output logic [ADDR_W-1:0] c_addr,
  output logic [DATA_W-1:0] c_wdata,
  input  logic [DATA_W-1:0] c_rdata,
  input  logic              c_rvalid,
  input  logic              c_wvalid,
  input  logic              c_ready,
  output logic              busy,
  output logic              err
);

  state_t            r_state;
  logic              r_owner;
  logic              r_rw;
  logic [ADDR_W-1:0] r_addr;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_rw_en;
  logic              r_grant0;
  logic              r_grant1;
  logic              r_done0;
  logic              r_done1;
  logic              r_err;

  logic w_idle;
  logic w_burst;
  logic w_arb_en;
  logic w_win;
  logic w_valid;
  logic w_full;
  logic w_route;

  assign w_idle   = (r_state == ST_IDLE);
  assign w_burst  = (r_state == ST_BURST);
  assign w_arb_en = w_idle && c_ready && (p0_req || p1_req);
  assign w_valid  = r_rw ? c_rvalid : c_wvalid;
  assign w_full   = (r_cnt == CNT_W'(BURST_LEN));
  assign w_route  = w_burst && w_valid && !w_full;

  sdram_arb_prio #(
    .STARVE_MAX (STARVE_MAX)
  ) u_prio (
    .CLK_OUT  (CLK_OUT),
    .rst_n    (rst_n),
    .i_arb_en (w_arb_en),
    .i_req0   (p0_req),
    .i_req1   (p1_req),
    .o_win    (w_win)
  );

  always_ff @(posedge CLK_OUT or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_owner  <= 1'b0;
      r_rw     <= 1'b0;
      r_addr   <= '0;
      r_cnt    <= '0;
      r_rw_en  <= 1'b0;
      r_grant0 <= 1'b0;
      r_grant1 <= 1'b0;
      r_done0  <= 1'b0;
      r_done1  <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_grant0 <= 1'b0;
      r_grant1 <= 1'b0;
      r_done0  <= 1'b0;
      r_done1  <= 1'b0;
      r_rw_en  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_arb_en) begin
            r_owner  <= w_win;
            r_rw     <= w_win ? p1_rw : p0_rw;
            r_addr   <= w_win ? p1_addr : p0_addr;
            r_grant0 <= !w_win;
            r_grant1 <= w_win;
            r_state  <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_rw_en <= 1'b1;
          r_state <= ST_BURST;
        end
        ST_BURST: begin
          // Overrun words are dropped and flagged; done waits for a quiet cycle.
          if (w_valid) begin
            if (!w_full) r_cnt <= r_cnt + CNT_W'(1);
            else         r_err <= 1'b1;
          end else if (w_full) begin
            r_done0 <= !r_owner;
            r_done1 <= r_owner;
            r_cnt   <= '0;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign p0_grant  = r_grant0;
  assign p1_grant  = r_grant1;
  assign p0_done   = r_done0;
  assign p1_done   = r_done1;
  assign c_rw_en   = r_rw_en;
  assign c_rw      = r_rw;
  assign c_addr    = r_addr;
  assign err       = r_err;
  assign busy      = !w_idle;

  assign p0_rvalid = w_route && r_rw && !r_owner;
  assign p1_rvalid = w_route && r_rw && r_owner;
  assign p0_wreq   = w_route && !r_rw && !r_owner;
  assign p1_wreq   = w_route && !r_rw && r_owner;

  // Data paths are forced low while reset is held so every output reads 0.
  assign p0_rdata  = rst_n ? c_rdata : '0;
  assign p1_rdata  = rst_n ? c_rdata : '0;
  assign c_wdata   = !rst_n ? '0 : (r_owner ? p1_wdata : p0_wdata);

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: stimulus queues expected grant/issue/done
// events, an independent negedge monitor pops and checks them.
module tb_sdram_arbiter;

  logic        CLK_OUT;
  logic        rst_n;
  logic        p0_req, p1_req, p0_rw, p1_rw;
  logic [14:0] p0_addr, p1_addr;
  logic [15:0] p0_wdata, p1_wdata;
  logic        p0_grant, p1_grant, p0_wreq, p1_wreq;
  logic [15:0] p0_rdata, p1_rdata;
  logic        p0_rvalid, p1_rvalid, p0_done, p1_done;
  logic        c_rw, c_rw_en;
  logic [14:0] c_addr;
  logic [15:0] c_wdata, c_rdata;
  logic        c_rvalid, c_wvalid, c_ready;
  logic        busy, err;

  sdram_arbiter dut (
    .CLK_OUT   (CLK_OUT),
    .rst_n     (rst_n),
    .p0_req    (p0_req),
    .p1_req    (p1_req),
    .p0_rw     (p0_rw),
    .p1_rw     (p1_rw),
    .p0_addr   (p0_addr),
    .p1_addr   (p1_addr),
    .p0_wdata  (p0_wdata),
    .p1_wdata  (p1_wdata),
    .p0_grant  (p0_grant),
    .p1_grant  (p1_grant),
    .p0_wreq   (p0_wreq),
    .p1_wreq   (p1_wreq),
    .p0_rdata  (p0_rdata),
    .p1_rdata  (p1_rdata),
    .p0_rvalid (p0_rvalid),
    .p1_rvalid (p1_rvalid),
    .p0_done   (p0_done),
    .p1_done   (p1_done),
    .c_rw      (c_rw),
    .c_rw_en   (c_rw_en),
    .c_addr    (c_addr),
    .c_wdata   (c_wdata),
    .c_rdata   (c_rdata),
    .c_rvalid  (c_rvalid),
    .c_wvalid  (c_wvalid),
    .c_ready   (c_ready),
    .busy      (busy),
    .err       (err)
  );

  initial CLK_OUT = 1'b0;
  always #5 CLK_OUT = ~CLK_OUT;

  localparam int K_GRANT = 0, K_ISSUE = 1, K_DONE = 2;
  localparam int W_G0 = 0, W_G1 = 1, W_ISS = 2, W_DONE = 3, W_GANY = 4;

  typedef struct {
    int          kind;
    int          port;
    bit          rw;
    logic [14:0] addr;
    int          words;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_fail = 0;

  function void check(input string nm, input logic [127:0] act, input logic [127:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endfunction

  function void push_txn(input int port, input bit rw, input logic [14:0] addr,
                         input int words, input bit with_done);
    q.push_back('{kind: K_GRANT, port: port, rw: rw, addr: addr, words: words});
    q.push_back('{kind: K_ISSUE, port: port, rw: rw, addr: addr, words: words});
    if (with_done)
      q.push_back('{kind: K_DONE, port: port, rw: rw, addr: addr, words: words});
  endfunction

  task automatic pop(input int kind, output exp_t e);
    if (q.size() == 0) begin
      e = '{kind: -1, port: -1, rw: 1'b0, addr: '0, words: -1};
      check("unexpected_event", kind, 99);
    end else begin
      e = q.pop_front();
      check("event_kind", e.kind, kind);
    end
  endtask

  // Monitor: checks DUT-presented events against the expectation queue.
  int          rc[2];
  int          wc[2];
  logic [14:0] cur_addr;
  initial begin
    exp_t e;
    int   x0r, x1r, x0w, x1w;
    rc = '{0, 0};
    wc = '{0, 0};
    cur_addr = '0;
    forever begin
      @(negedge CLK_OUT);
      if (!rst_n) begin
        rc = '{0, 0};
        wc = '{0, 0};
      end else begin
        if (p0_grant || p1_grant) begin
          pop(K_GRANT, e);
          check("grant_port", {p1_grant, p0_grant}, (e.port == 1) ? 2'b10 : 2'b01);
        end
        if (c_rw_en) begin
          pop(K_ISSUE, e);
          check("issue_rw_addr", {c_rw, c_addr}, {e.rw, e.addr});
          cur_addr = e.addr;
          rc = '{0, 0};
          wc = '{0, 0};
        end
        if (p0_rvalid) begin
          check("p0_rdata", p0_rdata, 16'h5A00 ^ 16'(rc[0]));
          rc[0]++;
        end
        if (p1_rvalid) begin
          check("p1_rdata", p1_rdata, 16'h5A00 ^ 16'(rc[1]));
          rc[1]++;
        end
        if (p0_wreq) begin
          check("p0_wdata", c_wdata, 16'({1'b0, cur_addr}) + 16'(wc[0]));
          wc[0]++;
        end
        if (p1_wreq) begin
          check("p1_wdata", c_wdata, 16'({1'b0, cur_addr}) + 16'(wc[1]));
          wc[1]++;
        end
        if (p0_done || p1_done) begin
          pop(K_DONE, e);
          check("done_port", {p1_done, p0_done}, (e.port == 1) ? 2'b10 : 2'b01);
          x0r = (e.port == 0 &&  e.rw) ? e.words : 0;
          x1r = (e.port == 1 &&  e.rw) ? e.words : 0;
          x0w = (e.port == 0 && !e.rw) ? e.words : 0;
          x1w = (e.port == 1 && !e.rw) ? e.words : 0;
          check("done_word_counts", {rc[0], rc[1], wc[0], wc[1]}, {x0r, x1r, x0w, x1w});
        end
      end
    end
  end

  task automatic wait_for(input int which, input int limit, output int cyc);
    bit hit;
    hit = 1'b0;
    cyc = 0;
    while (!hit && cyc < limit) begin
      @(negedge CLK_OUT);
      cyc++;
      case (which)
        W_G0:    hit = p0_grant;
        W_G1:    hit = p1_grant;
        W_ISS:   hit = c_rw_en;
        W_DONE:  hit = p0_done | p1_done;
        default: hit = p0_grant | p1_grant;
      endcase
    end
    if (!hit) begin
      n_chk++;
      n_fail++;
      $display("FAIL wait_timeout event=%0d not seen within %0d cycles", which, limit);
      cyc = -1;
    end
  endtask

  // Controller model: presents n consecutive valid words after c_rw_en.
  task automatic serve(input int port, input bit rw, input logic [14:0] addr, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK_OUT); #1;
      if (rw) begin
        c_rvalid = 1'b1;
        c_rdata  = 16'h5A00 ^ 16'(i);
      end else begin
        c_wvalid = 1'b1;
        if (port == 0) begin
          p0_wdata = 16'({1'b0, addr}) + 16'(i);
          p1_wdata = 16'hDEAD;
        end else begin
          p1_wdata = 16'({1'b0, addr}) + 16'(i);
          p0_wdata = 16'hDEAD;
        end
      end
    end
    @(posedge CLK_OUT); #1;
    c_rvalid = 1'b0;
    c_wvalid = 1'b0;
  endtask

  task automatic burst(input int port, input bit rw, input logic [14:0] addr, input int n,
                       input bit to_done, output int g_cyc, output int i_cyc);
    int d;
    push_txn(port, rw, addr, (n > 512) ? 512 : n, to_done);
    if (port == 0) begin p0_rw = rw; p0_addr = addr; end
    else           begin p1_rw = rw; p1_addr = addr; end
    @(posedge CLK_OUT); #1;
    if (port == 0) p0_req = 1'b1; else p1_req = 1'b1;
    wait_for((port == 0) ? W_G0 : W_G1, 10, g_cyc);
    p0_req = 1'b0;
    p1_req = 1'b0;
    wait_for(W_ISS, 5, i_cyc);
    serve(port, rw, addr, n);
    if (to_done) wait_for(W_DONE, 10, d);
  endtask

  function logic [127:0] out_vec();
    return {p0_grant, p1_grant, p0_wreq, p1_wreq, p0_rdata, p1_rdata, p0_rvalid, p1_rvalid,
            p0_done, p1_done, c_rw, c_rw_en, c_addr, c_wdata, busy, err};
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int g, i, c;
    rst_n = 1'b0;
    p0_req = 1'b0; p1_req = 1'b0; p0_rw = 1'b0; p1_rw = 1'b0;
    p0_addr = '0; p1_addr = '0; p0_wdata = 16'h3333; p1_wdata = 16'h4444;
    c_rdata = 16'h7777; c_rvalid = 1'b0; c_wvalid = 1'b0; c_ready = 1'b1;

    #12;
    check("reset_outputs_zero", out_vec(), '0);
    @(posedge CLK_OUT); #1;
    rst_n = 1'b1;

    // single read burst from port 0
    burst(0, 1'b1, 15'h0010, 512, 1'b1, g, i);
    check("t1_grant_latency", g, 2);
    check("t1_issue_latency", i, 1);
    check("t1_err_clear", err, 1'b0);
    check("t1_idle_after_done", busy, 1'b0);

    // simultaneous requests: p0 first, p1 on the cycle after p0_done
    repeat (2) @(negedge CLK_OUT);
    p0_rw = 1'b1; p0_addr = 15'h0020; p1_rw = 1'b0; p1_addr = 15'h1234;
    push_txn(0, 1'b1, 15'h0020, 512, 1'b1);
    push_txn(1, 1'b0, 15'h1234, 512, 1'b1);
    @(posedge CLK_OUT); #1;
    p0_req = 1'b1; p1_req = 1'b1;
    wait_for(W_G0, 10, c);
    p0_req = 1'b0;
    wait_for(W_ISS, 5, c);
    serve(0, 1'b1, 15'h0020, 512);
    wait_for(W_DONE, 10, c);
    wait_for(W_G1, 5, c);
    check("t2_p1_grant_after_done", c, 1);
    p1_req = 1'b0;
    wait_for(W_ISS, 5, c);
    serve(1, 1'b0, 15'h1234, 512);
    wait_for(W_DONE, 10, c);

    // starvation: p0 continuous, p1 held -> p0,p0,p0,p0,p1
    repeat (2) @(negedge CLK_OUT);
    p0_rw = 1'b1; p0_addr = 15'h0100; p1_rw = 1'b1; p1_addr = 15'h0200;
    for (int k = 0; k < 4; k++) push_txn(0, 1'b1, 15'h0100, 512, 1'b1);
    push_txn(1, 1'b1, 15'h0200, 512, 1'b1);
    @(posedge CLK_OUT); #1;
    p0_req = 1'b1; p1_req = 1'b1;
    for (int k = 0; k < 5; k++) begin
      wait_for(W_GANY, 10, c);
      if (k == 4) begin p0_req = 1'b0; p1_req = 1'b0; end
      wait_for(W_ISS, 5, c);
      serve(0, 1'b1, 15'h0000, 512);
      wait_for(W_DONE, 10, c);
    end
    repeat (3) @(negedge CLK_OUT);
    check("t3_idle_after_sequence", busy, 1'b0);

    // overrun: 513 read words -> 512 routed, sticky err
    check("t4_err_before", err, 1'b0);
    burst(0, 1'b1, 15'h0300, 513, 1'b1, g, i);
    check("t4_grant_latency", g, 2);
    check("t4_err_set", err, 1'b1);
    repeat (5) @(negedge CLK_OUT);
    check("t4_err_sticky", err, 1'b1);

    // reset at word 200 of a burst
    burst(0, 1'b1, 15'h0400, 200, 1'b0, g, i);
    c_rvalid = 1'b1;
    c_rdata  = 16'hBEEF;
    p0_wdata = 16'h1111;
    #1 rst_n = 1'b0;
    #1 check("t5_outputs_zero_in_reset", out_vec(), '0);
    repeat (2) @(posedge CLK_OUT);
    #1;
    c_rvalid = 1'b0;
    rst_n = 1'b1;

    // after release: no grant while c_ready low, then a normal write burst
    p1_rw = 1'b0; p1_addr = 15'h0555;
    c_ready = 1'b0;
    p1_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK_OUT);
      check("t5_no_grant_not_ready", {p1_grant, p0_grant, busy}, 3'b000);
    end
    c_ready = 1'b1;
    burst(1, 1'b0, 15'h0555, 512, 1'b1, g, i);
    check("t5_err_after_reset", err, 1'b0);

    repeat (3) @(negedge CLK_OUT);
    check("queue_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sdram_arbiter.md
SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 SHALL have parameter BURST_LEN, default 512, words per full-page burst (1..1023).
REQ-002 SHALL have parameter STARVE_MAX, default 4, consecutive port-0 wins allowed while port 1 is pending.
REQ-003 SHALL have port CLK_OUT  input  1  clock, all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports p0_req / p1_req  input  1  burst request, held until grant.
REQ-006 SHALL have ports p0_rw / p1_rw  input  1  1 = read, 0 = write; sampled with req.
REQ-007 SHALL have ports p0_addr / p1_addr  input  15  row/bank burst address.
REQ-008 SHALL have ports p0_wdata / p1_wdata  input  16  write word, valid before edge ending pN_wreq cycle.
REQ-009 SHALL have ports p0_grant / p1_grant  output  1  one-cycle pulse: request accepted.
REQ-010 SHALL have ports p0_wreq / p1_wreq  output  1  current write word consumed this cycle.
REQ-011 SHALL have ports p0_rdata / p1_rdata  output  16  read word.
REQ-012 SHALL have ports p0_rvalid / p1_rvalid  output  1  pN_rdata valid this cycle.
REQ-013 SHALL have ports p0_done / p1_done  output  1  one-cycle pulse: burst finished.
REQ-014 SHALL have controller-side ports c_rw out 1, c_rw_en out 1, c_addr out 15, c_wdata out 16, c_rdata in 16, c_rvalid in 1 (s2f valid), c_wvalid in 1 (f2s valid), c_ready in 1.
REQ-015 SHALL have ports busy  output  1  state != IDLE; err  output  1  sticky overrun flag.

Function
REQ-016 SHALL implement FSM IDLE -> ISSUE -> BURST -> IDLE; no other states.
REQ-017 IDLE: when c_ready=1 and any req=1, SHALL pick winner, register owner, rw, addr; pulse winner's grant the same cycle; go ISSUE.
REQ-018 IDLE with c_ready=0 SHALL issue nothing and SHALL NOT grant.
REQ-019 Arbitration: port 0 wins when both request, unless starve count = STARVE_MAX, in which case port 1 wins.
REQ-020 Starve count SHALL increment on each port-0 win while p1_req=1, and clear on a port-1 win or when p1_req=0 at arbitration; it saturates at STARVE_MAX.
REQ-021 ISSUE: c_rw_en SHALL be 1 for exactly one cycle with registered c_rw/c_addr; then go BURST.
REQ-022 c_addr and c_rw SHALL hold stable from ISSUE through end of BURST.
REQ-023 BURST: 10-bit word counter SHALL increment on each c_wvalid (write) or c_rvalid (read) cycle.
REQ-024 c_wdata SHALL be the owner's pN_wdata combinationally; pN_wreq = c_wvalid AND owner=N AND write burst.
REQ-025 pN_rdata SHALL equal c_rdata (broadcast); pN_rvalid = c_rvalid AND owner=N AND read burst, zero added latency.
REQ-026 When counter = BURST_LEN and the relevant valid is 0, SHALL pulse owner's done, clear counter, go IDLE.
REQ-027 Valid beyond BURST_LEN SHALL NOT be routed and SHALL set err until reset.
REQ-028 Earliest new grant after done SHALL be the cycle after done (one IDLE cycle minimum).
REQ-029 Requests arriving during ISSUE/BURST SHALL wait; non-owner grant, wreq, rvalid, done SHALL stay 0.

Reset
REQ-030 rst_n low SHALL force state IDLE, counters 0, owner 0, err 0, and every output 0 immediately, including mid-burst.
REQ-031 First arbitration SHALL occur no earlier than the first rising edge after rst_n deasserts.

Structure
REQ-032 Shared package sdram_arb_pkg SHALL hold the FSM state type, ADDR_W=15, DATA_W=16, and default BURST_LEN.
REQ-033 Winner selection and starve counter SHALL be sub-module sdram_arb_prio; datapath muxing stays in sdram_arbiter.

Verification
REQ-034 p0_req only, read, addr 0x0010, c_ready=1 -> p0_grant next edge, c_rw_en one cycle later with c_addr=0x0010, 512 p0_rvalid, p0_done once, p1 outputs all 0.
REQ-035 p0 and p1 both request in the same cycle -> p0 granted; p1 granted right after p0_done+1 cycle once p0_req drops.
REQ-036 p0 requests continuously, p1 held -> grant order p0,p0,p0,p0,p1 with STARVE_MAX=4.
REQ-037 p1 write, wdata = address + index -> exactly 512 p1_wreq pulses, c_wdata tracks p1_wdata every cycle.
REQ-038 Model emits 513 c_rvalid -> 512 routed, err=1 and sticky.
REQ-039 rst_n asserted at word 200 of a burst -> all outputs 0 immediately, busy=0; new request after release is granted normally.
